// File: rtl/game_dumper.sv
// game_dumper: streams a loaded cartridge image out as an iNES byte stream.
// A 16-byte iNES 1.0 header is generated from the geometry latched at start,
// followed by the PRG region and then the CHR region read one byte at a time
// from the cartridge memory arbiter. Output is a valid/ready byte stream.
module game_dumper #(
  parameter logic [21:0] PRG_BASE    = 22'h000000,
  parameter logic [21:0] CHR_BASE    = 22'h200000,
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  prg_pages,
  input  logic [7:0]  chr_pages,
  input  logic [7:0]  mapper,
  input  logic        mirroring,
  input  logic        four_screen,
  output logic [21:0] mem_addr,
  output logic        mem_read,
  input  logic        mem_ack,
  input  logic [7:0]  mem_rdata,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy,
  output logic        done,
  output logic        error
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    HDR    = 3'd1,
    RD_REQ = 3'd2,
    SEND   = 3'd3,
    DONE   = 3'd4,
    ERR    = 3'd5
  } state_t;

  // Last count value before the ack wait is declared lost.
  localparam logic [7:0] TIMEOUT_LAST = 8'(ACK_TIMEOUT - 1);

  state_t      state_r;
  logic [3:0]  hdr_idx_r;
  logic        seg_chr_r;
  logic [21:0] bytes_left_r;
  logic [7:0]  timeout_r;
  logic [7:0]  prg_r;
  logic [7:0]  chr_r;
  logic [7:0]  mapper_r;
  logic        mirroring_r;
  logic        four_screen_r;

  logic        handshake_s;
  logic [21:0] bytes_next_s;
  logic [21:0] addr_next_s;
  logic [3:0]  hdr_idx_next_s;
  logic        last_byte_s;
  logic        chr_follows_s;

  // iNES 1.0 header byte at position idx for the given geometry.
  function automatic logic [7:0] header_byte(
    input logic [3:0] idx,
    input logic [7:0] prg,
    input logic [7:0] chr,
    input logic [7:0] map,
    input logic       mir,
    input logic       fs
  );
    logic [7:0] b;
    case (idx)
      4'd0:    b = 8'h4E;
      4'd1:    b = 8'h45;
      4'd2:    b = 8'h53;
      4'd3:    b = 8'h1A;
      4'd4:    b = prg;
      4'd5:    b = chr;
      4'd6:    b = {map[3:0], fs, 1'b0, 1'b0, mir};
      4'd7:    b = {map[7:4], 4'b0000};
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  // PRG must be 1..128 pages so the region fits below CHR_BASE.
  function automatic logic geometry_ok(input logic [7:0] prg);
    return (prg != 8'd0) && (prg <= 8'd128);
  endfunction

  // Handshake and next-byte bookkeeping shared by the header and data phases.
  always_comb begin
    handshake_s    = out_valid && out_ready;
    bytes_next_s   = bytes_left_r - 22'd1;
    addr_next_s    = mem_addr + 22'd1;
    hdr_idx_next_s = hdr_idx_r + 4'd1;
    if (bytes_next_s == 22'd0) begin
      last_byte_s = 1'b1;
    end else begin
      last_byte_s = 1'b0;
    end
    if (!seg_chr_r && (chr_r != 8'd0)) begin
      chr_follows_s = 1'b1;
    end else begin
      chr_follows_s = 1'b0;
    end
  end

  // Dump sequencer: header, PRG then CHR; all outputs are registered here.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= IDLE;
      hdr_idx_r     <= 4'd0;
      seg_chr_r     <= 1'b0;
      bytes_left_r  <= 22'd0;
      timeout_r     <= 8'd0;
      prg_r         <= 8'd0;
      chr_r         <= 8'd0;
      mapper_r      <= 8'd0;
      mirroring_r   <= 1'b0;
      four_screen_r <= 1'b0;
      mem_addr      <= 22'd0;
      mem_read      <= 1'b0;
      out_data      <= 8'd0;
      out_valid     <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
    end else begin
      case (state_r)
        IDLE, DONE, ERR: begin
          if (start) begin
            prg_r         <= prg_pages;
            chr_r         <= chr_pages;
            mapper_r      <= mapper;
            mirroring_r   <= mirroring;
            four_screen_r <= four_screen;
            done          <= 1'b0;
            timeout_r     <= 8'd0;
            mem_read      <= 1'b0;
            if (geometry_ok(prg_pages)) begin
              // First header byte is presented on the very next cycle.
              state_r   <= HDR;
              hdr_idx_r <= 4'd0;
              out_data  <= header_byte(4'd0, prg_pages, chr_pages, mapper,
                                       mirroring, four_screen);
              out_valid <= 1'b1;
              busy      <= 1'b1;
              error     <= 1'b0;
            end else begin
              state_r   <= ERR;
              out_valid <= 1'b0;
              busy      <= 1'b0;
              error     <= 1'b1;
            end
          end else begin
            state_r <= state_r;
          end
        end

        HDR: begin
          if (handshake_s) begin
            if (hdr_idx_r == 4'd15) begin
              state_r      <= RD_REQ;
              out_valid    <= 1'b0;
              seg_chr_r    <= 1'b0;
              mem_addr     <= PRG_BASE;
              bytes_left_r <= {prg_r, 14'b0};
              mem_read     <= 1'b1;
              timeout_r    <= 8'd0;
            end else begin
              hdr_idx_r <= hdr_idx_next_s;
              out_data  <= header_byte(hdr_idx_next_s, prg_r, chr_r, mapper_r,
                                       mirroring_r, four_screen_r);
            end
          end else begin
            hdr_idx_r <= hdr_idx_r;
          end
        end

        RD_REQ: begin
          if (mem_ack) begin
            out_data  <= mem_rdata;
            out_valid <= 1'b1;
            mem_read  <= 1'b0;
            timeout_r <= 8'd0;
            state_r   <= SEND;
          end else if (timeout_r == TIMEOUT_LAST) begin
            // Memory never answered: abandon the request and flag it.
            mem_read  <= 1'b0;
            timeout_r <= 8'd0;
            busy      <= 1'b0;
            error     <= 1'b1;
            state_r   <= ERR;
          end else begin
            timeout_r <= timeout_r + 8'd1;
          end
        end

        SEND: begin
          if (handshake_s) begin
            out_valid <= 1'b0;
            if (!last_byte_s) begin
              mem_addr     <= addr_next_s;
              bytes_left_r <= bytes_next_s;
              mem_read     <= 1'b1;
              state_r      <= RD_REQ;
            end else if (chr_follows_s) begin
              // PRG finished; CHR ROM data follows.
              seg_chr_r    <= 1'b1;
              mem_addr     <= CHR_BASE;
              bytes_left_r <= {1'b0, chr_r, 13'b0};
              mem_read     <= 1'b1;
              state_r      <= RD_REQ;
            end else begin
              mem_addr     <= addr_next_s;
              bytes_left_r <= bytes_next_s;
              busy         <= 1'b0;
              done         <= 1'b1;
              state_r      <= DONE;
            end
          end else begin
            out_valid <= 1'b1;
          end
        end

        default: begin
          state_r   <= IDLE;
          mem_read  <= 1'b0;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/game_dumper.md
Name: game_dumper

Overview:
- Streams a loaded game back out of cartridge memory as a standard iNES byte stream, for save-to-SD and host-dump paths.
- Emits a 16-byte iNES 1.0 header built from the latched game geometry.
- Then reads and emits the PRG region, then the CHR region, over a valid/ready byte interface.
- Sits between the cartridge memory arbiter (read port) and the host/SD byte sink.

Parameters:
- PRG_BASE, 22'h000000, first PRG byte address
- CHR_BASE, 22'h200000, first CHR byte address
- ACK_TIMEOUT, 255, max cycles waiting for mem_ack before error (8-bit counter)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- start  in  1  one-cycle pulse; begin dump (ignored while busy)
- prg_pages  in  8  16 KiB PRG page count, latched at start
- chr_pages  in  8  8 KiB CHR page count (0 = CHR RAM, no CHR data), latched at start
- mapper  in  8  iNES mapper number, latched at start
- mirroring  in  1  header byte 6 bit 0, latched at start
- four_screen  in  1  header byte 6 bit 3, latched at start
- mem_addr  out  22  memory read address
- mem_read  out  1  read request, held until ack
- mem_ack  in  1  one-cycle pulse; mem_rdata valid this cycle
- mem_rdata  in  8  read data
- out_data  out  8  stream byte
- out_valid  out  1  out_data valid
- out_ready  in  1  sink accepts when valid&&ready
- busy  out  1  dump in progress
- done  out  1  sticky; full stream sent
- error  out  1  sticky; bad geometry or ack timeout

Behaviour:
- One clock, synchronous active-high reset.
- Reset values (also on reset mid-dump): all outputs 0, state IDLE, counters 0.
- Pending memory reads are abandoned on reset; the memory side must tolerate a dropped request.
- States: IDLE, HDR, RD_REQ, SEND, DONE, ERR.
- IDLE:
  - On start, latch inputs and clear done/error.
  - If prg_pages==0 or prg_pages>128, go to ERR.
  - Otherwise go to HDR with hdr_idx=0.
- busy=1 in HDR, RD_REQ, SEND.
- HDR:
  - out_valid=1; out_data=header[hdr_idx]; hdr_idx advances on handshake.
  - After byte 15 is accepted: segment=PRG, mem_addr=PRG_BASE, bytes_left=prg_pages*16384 (22-bit), go to RD_REQ.
- Header bytes:
  - 0..3 = 4E 45 53 1A
  - 4 = prg_pages
  - 5 = chr_pages
  - 6 = {mapper[3:0], four_screen, 1'b0, 1'b0, mirroring}
  - 7 = {mapper[7:4], 4'b0000}
  - 8..15 = 00
- RD_REQ:
  - mem_read=1 with mem_addr stable until mem_ack.
  - On mem_ack: capture mem_rdata into out_data, drop mem_read the same edge, clear the timeout counter, go to SEND.
  - Each cycle without ack increments the timeout counter. If it reaches ACK_TIMEOUT, go to ERR.
- SEND:
  - out_valid=1, out_data stable until handshake.
  - On handshake: mem_addr+1, bytes_left−1.
  - If the new bytes_left!=0, go to RD_REQ.
  - Else if segment==PRG and chr_pages!=0: segment=CHR, mem_addr=CHR_BASE, bytes_left=chr_pages*8192, go to RD_REQ.
  - Else go to DONE.
- Stream never stalls on its own: out_valid drops only between bytes while waiting for memory.
- DONE: done=1, busy=0, out_valid=0. A new start restarts the dump.
- ERR: error=1, busy=0, mem_read=0, out_valid=0. Exit only via start (re-validated) or reset.
- start is ignored in HDR, RD_REQ and SEND.
- Latency:
  - start at edge N gives out_valid=1 with out_data=4E from cycle N+1.
  - Each memory byte becomes valid 1 cycle after its mem_ack.
- Widths: PRG max 128*16384=2^21, so the PRG region never crosses CHR_BASE. CHR max 255*8192 < 2^21 from CHR_BASE, so the address never wraps.

Test Plan:
- prg_pages=1, chr_pages=1, mapper=0, mirroring=1, four_screen=0, out_ready=1, zero-wait memory model → 16 header bytes 4E 45 53 1A 01 01 01 00 00×8, then 16384 PRG bytes from 0x000000, then 8192 CHR bytes from 0x200000; done=1; total 24592 handshakes.
- mapper=0x42, four_screen=1, mirroring=0, prg_pages=2, chr_pages=0 → byte6=0x28, byte7=0x40; 32768 PRG bytes; no address ≥0x200000 issued; done=1.
- Random out_ready deassertion plus random 0–10 cycle ack delay → out_data stable while valid&&!ready; byte sequence identical to memory contents in order; no duplicate or missing addresses.
- start with prg_pages=0, then separately with prg_pages=129 → error=1 next cycle, no mem_read, no out_valid; later start with valid geometry clears error and dumps correctly.
- Memory never acks at the first PRG address → error=1 after ACK_TIMEOUT cycles of mem_read, mem_read then 0, busy=0.
- Reset asserted mid-PRG (after 100 bytes) → next cycle all outputs 0, state IDLE; a fresh start re-emits the header from 4E.
